alu_result_gather: RTL and testbench
====================================

Name: alu_result_gather

Overview:
- Sits at the output end of a lane-serialized execute unit (dot8, ALU, FPU) whose results arrive as NUM_THREADS/NUM_LANES partial packets tagged pid/sop/eop.
- Reassembles those packets into one full-warp result and presents it to writeback/commit as a single packet with sop=eop=1, pid=0.
- It is the receiver/deserializer counterpart of the lane serializer on the execute side.

Parameters:
INSTANCE_ID, "", trace label only
NUM_LANES, 1, lanes per incoming partial packet; divides `NUM_THREADS
NUM_THREADS, `NUM_THREADS, lanes per warp on the output
DATA_WIDTH, `XLEN, per-lane result width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
result_in_if  VX_result_if.slave  NUM_LANES-wide  partial results: valid, ready, uuid, wid, tmask[NUM_LANES], PC, wb, rd, data[NUM_LANES][DATA_WIDTH], pid[PID_WIDTH], sop, eop
result_out_if  VX_result_if.master  NUM_THREADS-wide  full-warp result, same fields, pid always 0, sop=eop=1

Interface timing: one clock (clk); reset is synchronous and active-high.

Behaviour:
- PID_COUNT = NUM_THREADS/NUM_LANES; PID_BITS = clog2(PID_COUNT); PID_WIDTH = max(PID_BITS,1).
- Storage:
  - gather buffer: data[NUM_THREADS], tmask[NUM_THREADS], and header (uuid, wid, PC, wb, rd).
  - one output register holding the complete packet.
- State machine:
  - IDLE: accepted beat with sop=1, eop=0 → GATHER. Header is captured, lanes pid*NUM_LANES..+NUM_LANES-1 are written, expected_pid = pid+1.
  - GATHER: an accepted non-sop beat writes its lane slice; expected_pid increments. An accepted eop beat → IDLE.
- eop handling:
  - When a beat with eop is accepted, the merged buffer plus that beat's slice loads the output register.
  - The buffer tmask clears in the same cycle.
  - The header comes from the sop beat; on a sop+eop beat it comes from that beat directly.
- Tmask/data: lanes not written in the current instruction read tmask 0 and data 0. Data is written regardless of tmask bits.
- Latency: eop beat accepted at cycle N → result_out valid at N+1. The output is registered; there is no combinational in→out path.
- Handshake:
  - out_fire = out_valid & out_ready.
  - in_ready = !(in_eop & out_valid & !out_ready).
  - Non-eop beats are accepted while the output is stalled. Only the completing beat waits.
  - Accepting an eop beat while out_fire in the same cycle is legal: the register reloads, valid stays 1, giving full throughput.
  - out_valid falls only on out_fire without a reload.
  - Output data and tag are stable while valid & !ready.
- PID_COUNT == 1: every beat is sop&eop and the block degenerates to a one-deep registered skid (latency 1).
- Protocol errors (simulation assertions only; hardware behaviour defined):
  - sop while in GATHER: discard the partial buffer and restart with the new beat.
  - pid != expected_pid while in GATHER: assert; the slice is still written at the received pid.
  - eop in IDLE without sop: treated as sop+eop.
- Reset: out_valid=0, state=IDLE, expected_pid=0, buffer tmask=0.
  - Output data and tag are don't-care but driven to 0.
  - Reset mid-gather discards the partial instruction; no output is produced for it.
- DBG_TRACE_PIPELINE: trace each out_fire with wid, PC, tmask, data.

Decomposition:
- VX_gpu_pkg holds UUID_WIDTH, NW_WIDTH, PC_BITS, NUM_REGS_BITS, and a new localparam function pid_count(NUM_THREADS, NUM_LANES) shared with the serializer.
- The header struct (uuid, wid, PC, wb, rd) becomes a package typedef result_hdr_t.
- One natural sub-module: alu_gather_outreg, the output register with reload-on-fire logic, reusable as an elastic stage.

Test Plan:
1. NUM_THREADS=4, NUM_LANES=1; beats pid0..3 with data 0x11,0x22,0x33,0x44, tmask all 1, out_ready=1 → one output one cycle after the pid3 beat: data {0x44,0x33,0x22,0x11}, tmask 4'b1111, header from pid0.
2. Same config, tmask pattern 1,0,1,0 → output tmask 4'b0101. Data lanes 1 and 3 carry the beat data written; untouched lanes in a subsequent instruction read 0.
3. Output stalled (out_ready=0) with a second instruction streaming → pid0..2 accepted, pid3 held (in_ready=0). Releasing out_ready gives back-to-back outputs; the first packet is unchanged while stalled.
4. NUM_LANES=NUM_THREADS=4; a sop&eop beat each cycle, out_ready=1 → output every cycle at latency 1, zero bubbles.
5. Reset asserted after pid1 of 4, then new instruction pid0..3 with uuid 7 → exactly one output with uuid 7; no stale lanes.
6. sop at pid0 arrives while gathering (pid2 expected) → assertion fires. The buffer restarts, and the subsequent complete instruction emits correctly.

Source files
------------

// File: rtl/alu_result_gather_pkg.sv
// Shared types and constants for the execute-side result path (gather and serializer).
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package alu_result_gather_pkg;

    localparam int UUID_WIDTH       = 44;
    localparam int NW_WIDTH         = 2;
    localparam int PC_BITS          = 30;
    localparam int NUM_REGS_BITS    = 5;
    localparam int NUM_THREADS_DFLT = 4;
    localparam int XLEN             = 32;

    // Number of partial packets that make up one warp.
    function automatic int pid_count(input int num_threads, input int num_lanes);
        return num_threads / num_lanes;
    endfunction

    // Width of the pid field; never narrower than one bit.
    function automatic int pid_width(input int num_threads, input int num_lanes);
        int cnt;
        cnt = pid_count(num_threads, num_lanes);
        return (cnt > 1) ? $clog2(cnt) : 1;
    endfunction

    // Per-instruction header, carried unchanged from the sop beat to writeback.
    typedef struct packed {
        logic [UUID_WIDTH-1:0]    uuid;
        logic [NW_WIDTH-1:0]      wid;
        logic [PC_BITS-1:0]       pc;
        logic                     wb;
        logic [NUM_REGS_BITS-1:0] rd;
    } result_hdr_t;

endpackage

// File: rtl/alu_result_gather_if.sv
// Result bus between execute units and writeback: header, lane mask, lane data, pid/sop/eop.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a beat transfers on a cycle where both are high.
interface alu_result_gather_if
    import alu_result_gather_pkg::*;
#(
    parameter int NUM_LANES  = 1,
    parameter int DATA_WIDTH = XLEN,
    parameter int PID_WIDTH  = 1
) ();

    logic                                  valid;
    logic                                  ready;
    result_hdr_t                           hdr;
    logic [NUM_LANES-1:0]                  tmask;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  data;
    logic [PID_WIDTH-1:0]                  pid;
    logic                                  sop;
    logic                                  eop;

    modport master (output valid, hdr, tmask, data, pid, sop, eop, input ready);
    modport slave  (input valid, hdr, tmask, data, pid, sop, eop, output ready);

endinterface

// File: rtl/alu_result_gather_outreg.sv
// One-entry elastic output register; reloads in the same cycle it is drained.
// Latency: 1 cycle in->out, no combinational data path.
// Backpressure: in_ready = !out_valid | out_ready, so full throughput when the sink is ready.
//
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_dat upstream;
//        out_valid/out_ready/out_dat downstream.
module alu_result_gather_outreg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_dat
);

    logic             vld_q;
    logic [WIDTH-1:0] dat_q;

    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;
    assign out_dat   = dat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (in_valid && in_ready) begin
            // Load (possibly while draining): valid stays high.
            vld_q <= 1'b1;
            dat_q <= in_dat;
        end else if (out_ready) begin
            vld_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_result_gather.sv
// Reassembles lane-serialized partial results (pid/sop/eop) into one full-warp packet.
// Latency: eop beat accepted at cycle N -> result_out valid at N+1 (registered output).
// Backpressure: non-eop beats always accepted; only the eop beat waits for the output register.
//
// Ports: clk, reset (sync, active-high);
//        result_in_if  (slave)  NUM_LANES-wide partial beats;
//        result_out_if (master) NUM_THREADS-wide full warp, pid=0, sop=eop=1.
module alu_result_gather
    import alu_result_gather_pkg::*;
#(
    parameter string INSTANCE_ID = "",
    parameter int    NUM_LANES   = 1,
    parameter int    NUM_THREADS = NUM_THREADS_DFLT,
    parameter int    DATA_WIDTH  = XLEN
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_result_gather_if.slave    result_in_if,
    alu_result_gather_if.master   result_out_if
);

    localparam int PID_COUNT = pid_count(NUM_THREADS, NUM_LANES);
    localparam int PID_BITS  = (PID_COUNT > 1) ? $clog2(PID_COUNT) : 0;
    localparam int PID_WIDTH = (PID_BITS > 0) ? PID_BITS : 1;
    localparam int OUT_WIDTH = $bits(result_hdr_t) + NUM_THREADS + NUM_THREADS * DATA_WIDTH;

    typedef logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] warp_data_t;
    typedef enum logic {ST_IDLE, ST_GATHER} state_t;

    state_t                 state;
    logic [PID_WIDTH-1:0]   expected_pid;
    result_hdr_t            buf_hdr;
    logic [NUM_THREADS-1:0] buf_tmask;
    warp_data_t             buf_data;

    logic [PID_WIDTH-1:0]   in_pid;
    logic                   in_fire;
    logic                   is_start;
    result_hdr_t            mrg_hdr;
    logic [NUM_THREADS-1:0] mrg_tmask;
    warp_data_t             mrg_data;

    logic                   oreg_in_rdy;
    logic [OUT_WIDTH-1:0]   oreg_out_dat;
    result_hdr_t            out_hdr;
    logic [NUM_THREADS-1:0] out_tmask;
    warp_data_t             out_data;

    assign in_pid = result_in_if.pid;

    // Only the completing beat needs room in the output register.
    assign result_in_if.ready = !result_in_if.eop || oreg_in_rdy;
    assign in_fire            = result_in_if.valid && result_in_if.ready;

    // A sop beat always restarts the instruction (this also recovers from a
    // missing eop), and any beat seen while idle is treated as a start so an
    // orphan eop becomes a single-beat instruction.
    assign is_start = result_in_if.sop || (state == ST_IDLE);

    always_comb begin
        mrg_hdr   = is_start ? result_in_if.hdr : buf_hdr;
        mrg_tmask = is_start ? '0 : buf_tmask;
        mrg_data  = is_start ? '0 : buf_data;
        // Slice is written at the received pid, even if it is out of order.
        for (int i = 0; i < PID_COUNT; i++) begin
            if (in_pid == PID_WIDTH'(i)) begin
                for (int j = 0; j < NUM_LANES; j++) begin
                    mrg_tmask[i*NUM_LANES + j] = result_in_if.tmask[j];
                    mrg_data[i*NUM_LANES + j]  = result_in_if.data[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            expected_pid <= '0;
            buf_hdr      <= '0;
            buf_tmask    <= '0;
            buf_data     <= '0;
        end else if (in_fire) begin
            if (result_in_if.eop) begin
                // Merged packet goes to the output register this cycle.
                state        <= ST_IDLE;
                expected_pid <= '0;
                buf_tmask    <= '0;
                buf_data     <= '0;
            end else begin
                state        <= ST_GATHER;
                expected_pid <= in_pid + 1'b1;
                buf_hdr      <= mrg_hdr;
                buf_tmask    <= mrg_tmask;
                buf_data     <= mrg_data;
            end
        end
    end

    alu_result_gather_outreg #(
        .WIDTH (OUT_WIDTH)
    ) u_outreg (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (result_in_if.valid && result_in_if.eop),
        .in_ready  (oreg_in_rdy),
        .in_dat    ({mrg_hdr, mrg_tmask, mrg_data}),
        .out_valid (result_out_if.valid),
        .out_ready (result_out_if.ready),
        .out_dat   (oreg_out_dat)
    );

    assign {out_hdr, out_tmask, out_data} = oreg_out_dat;

    assign result_out_if.hdr   = out_hdr;
    assign result_out_if.tmask = out_tmask;
    assign result_out_if.data  = out_data;
    assign result_out_if.pid   = '0;
    assign result_out_if.sop   = 1'b1;
    assign result_out_if.eop   = 1'b1;

`ifndef SYNTHESIS
    // Protocol monitors: hardware behaviour is defined, these only flag the upstream bug.
    always_ff @(posedge clk) begin
        if (!reset && in_fire && state == ST_GATHER) begin
            if (result_in_if.sop)
                $warning("%s: sop while gathering, partial instruction dropped", INSTANCE_ID);
            else if (in_pid != expected_pid)
                $warning("%s: pid %0d while expecting %0d", INSTANCE_ID, in_pid, expected_pid);
        end
    end
`endif

`ifdef DBG_TRACE_PIPELINE
    always_ff @(posedge clk) begin
        if (!reset && result_out_if.valid && result_out_if.ready)
            $display("%t %s: wid=%0d PC=0x%0h tmask=%b data=%0h", $time, INSTANCE_ID,
                     out_hdr.wid, {out_hdr.pc, 2'b00}, out_tmask, out_data);
    end
`endif

endmodule

// File: tb/tb_alu_result_gather.sv
module tb_alu_result_gather;
    import alu_result_gather_pkg::*;

    typedef struct {
        result_hdr_t hdr;
        logic [3:0]   tmask;
        logic [127:0] data;
        int           cyc;
    } pkt_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    pkt_t a_q[$];
    pkt_t b_q[$];

    alu_result_gather_if #(.NUM_LANES(1), .DATA_WIDTH(32), .PID_WIDTH(2)) a_in ();
    alu_result_gather_if #(.NUM_LANES(4), .DATA_WIDTH(32), .PID_WIDTH(1)) a_out ();
    alu_result_gather_if #(.NUM_LANES(4), .DATA_WIDTH(32), .PID_WIDTH(1)) b_in ();
    alu_result_gather_if #(.NUM_LANES(4), .DATA_WIDTH(32), .PID_WIDTH(1)) b_out ();

    alu_result_gather #(.INSTANCE_ID("gather_a"), .NUM_LANES(1), .NUM_THREADS(4), .DATA_WIDTH(32))
        dut_a (.clk(clk), .reset(reset), .result_in_if(a_in), .result_out_if(a_out));
    alu_result_gather #(.INSTANCE_ID("gather_b"), .NUM_LANES(4), .NUM_THREADS(4), .DATA_WIDTH(32))
        dut_b (.clk(clk), .reset(reset), .result_in_if(b_in), .result_out_if(b_out));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every transfer on the output side, half a cycle before the edge.
    always @(negedge clk) begin
        pkt_t p;
        if (a_out.valid && a_out.ready) begin
            p.hdr = a_out.hdr; p.tmask = a_out.tmask; p.data = a_out.data; p.cyc = cyc;
            a_q.push_back(p);
        end
        if (b_out.valid && b_out.ready) begin
            p.hdr = b_out.hdr; p.tmask = b_out.tmask; p.data = b_out.data; p.cyc = cyc;
            b_q.push_back(p);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic result_hdr_t mk_hdr(input logic [43:0] uid);
        result_hdr_t h;
        h.uuid = uid;
        h.wid  = uid[1:0];
        h.pc   = 30'h400 + uid[29:0];
        h.wb   = 1'b1;
        h.rd   = uid[4:0];
        return h;
    endfunction

    // Non-sop beats carry a different header so the output proves it came from sop.
    task automatic send_a(input int pid, input bit sop, input bit eop, input bit tm,
                          input logic [31:0] d, input logic [43:0] uid, output int acc);
        a_in.valid = 1'b1; a_in.pid = 2'(pid); a_in.sop = sop; a_in.eop = eop;
        a_in.tmask = tm; a_in.data[0] = d;
        a_in.hdr = mk_hdr(sop ? uid : uid + 44'd100);
        acc = -1;
        for (int n = 0; n < 40 && acc < 0; n++) begin
            @(negedge clk);
            if (a_in.ready) acc = cyc;
            @(posedge clk); #1;
        end
        a_in.valid = 1'b0;
        if (acc < 0) check("a_accept_timeout", 0, 1);
    endtask

    task automatic send_b(input logic [3:0] tm, input logic [127:0] d,
                          input logic [43:0] uid, output int acc);
        b_in.valid = 1'b1; b_in.pid = 1'b0; b_in.sop = 1'b1; b_in.eop = 1'b1;
        b_in.tmask = tm; b_in.data = d; b_in.hdr = mk_hdr(uid);
        acc = -1;
        for (int n = 0; n < 40 && acc < 0; n++) begin
            @(negedge clk);
            if (b_in.ready) acc = cyc;
            @(posedge clk); #1;
        end
        b_in.valid = 1'b0;
        if (acc < 0) check("b_accept_timeout", 0, 1);
    endtask

    task automatic send4_a(input logic [43:0] uid, input logic [3:0] tm,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, output int acc3);
        int acc;
        send_a(0, 1, 0, tm[0], d0, uid, acc);
        send_a(1, 0, 0, tm[1], d1, uid, acc);
        send_a(2, 0, 0, tm[2], d2, uid, acc);
        send_a(3, 0, 1, tm[3], d3, uid, acc3);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        pkt_t p;
        int   acc, acc_b0, acc_b1, acc_b2;

        a_in.valid = 0; a_in.pid = 0; a_in.sop = 0; a_in.eop = 0; a_in.tmask = 0;
        a_in.data = '0; a_in.hdr = '0; a_out.ready = 1;
        b_in.valid = 0; b_in.pid = 0; b_in.sop = 0; b_in.eop = 0; b_in.tmask = 0;
        b_in.data = '0; b_in.hdr = '0; b_out.ready = 1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_a_valid", a_out.valid, 0);
        check("rst_b_valid", b_out.valid, 0);
        check("rst_a_data", a_out.data, 0);
        check("rst_a_tmask", a_out.tmask, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("idle_a_ready", a_in.ready, 1);
        @(posedge clk); #1;

        // 1: four single-lane beats, all lanes active.
        a_q.delete();
        send4_a(44'd1, 4'b1111, 32'h11, 32'h22, 32'h33, 32'h44, acc);
        settle();
        check("t1_count", a_q.size(), 1);
        if (a_q.size() > 0) begin
            p = a_q.pop_front();
            check("t1_data", p.data, 128'h00000044_00000033_00000022_00000011);
            check("t1_tmask", p.tmask, 4'b1111);
            check("t1_uuid", p.hdr.uuid, 1);
            check("t1_pc", p.hdr.pc, 30'h401);
            check("t1_latency", p.cyc - acc, 1);
        end
        check("t1_out_idle", a_out.valid, 0);

        // 2: partial mask; then a short instruction leaves upper lanes untouched.
        send4_a(44'd2, 4'b0101, 32'hA0, 32'hA1, 32'hA2, 32'hA3, acc);
        send_a(0, 1, 0, 1, 32'hB0, 44'd3, acc);
        send_a(1, 0, 1, 1, 32'hB1, 44'd3, acc);
        settle();
        check("t2_count", a_q.size(), 2);
        if (a_q.size() == 2) begin
            p = a_q.pop_front();
            check("t2_tmask", p.tmask, 4'b0101);
            check("t2_data", p.data, 128'h000000A3_000000A2_000000A1_000000A0);
            p = a_q.pop_front();
            check("t2b_tmask", p.tmask, 4'b0011);
            check("t2b_data", p.data, 128'h00000000_00000000_000000B1_000000B0);
            check("t2b_uuid", p.hdr.uuid, 3);
        end

        // 3: output stalled; second instruction streams, only its eop waits.
        a_out.ready = 0;
        send4_a(44'd4, 4'b1111, 32'hC0, 32'hC1, 32'hC2, 32'hC3, acc);
        send_a(0, 1, 0, 1, 32'hD0, 44'd5, acc);
        send_a(1, 0, 0, 1, 32'hD1, 44'd5, acc);
        send_a(2, 0, 0, 1, 32'hD2, 44'd5, acc);
        a_in.valid = 1; a_in.pid = 2'd3; a_in.sop = 0; a_in.eop = 1; a_in.tmask = 1;
        a_in.data[0] = 32'hD3; a_in.hdr = mk_hdr(44'd105);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_ready", a_in.ready, 0);
            check("t3_hold_valid", a_out.valid, 1);
            check("t3_hold_uuid", a_out.hdr.uuid, 4);
            check("t3_hold_data", a_out.data, 128'h000000C3_000000C2_000000C1_000000C0);
            @(posedge clk); #1;
        end
        a_out.ready = 1;
        @(negedge clk);
        check("t3_release_ready", a_in.ready, 1);
        @(posedge clk); #1;
        a_in.valid = 0;
        settle();
        check("t3_count", a_q.size(), 2);
        if (a_q.size() == 2) begin
            p = a_q.pop_front();
            acc = p.cyc;
            check("t3_first_uuid", p.hdr.uuid, 4);
            p = a_q.pop_front();
            check("t3_second_uuid", p.hdr.uuid, 5);
            check("t3_second_data", p.data, 128'h000000D3_000000D2_000000D1_000000D0);
            check("t3_back_to_back", p.cyc - acc, 1);
        end

        // 4: full-width lanes, one sop&eop beat per cycle.
        b_q.delete();
        send_b(4'b1111, 128'h13_12_11_10, 44'd20, acc_b0);
        send_b(4'b0110, 128'h23_22_21_20, 44'd21, acc_b1);
        send_b(4'b1001, 128'h33_32_31_30, 44'd22, acc_b2);
        settle();
        check("t4_accept_gap1", acc_b1 - acc_b0, 1);
        check("t4_accept_gap2", acc_b2 - acc_b1, 1);
        check("t4_count", b_q.size(), 3);
        if (b_q.size() == 3) begin
            p = b_q.pop_front();
            check("t4_lat0", p.cyc - acc_b0, 1);
            check("t4_data0", p.data, 128'h13_12_11_10);
            p = b_q.pop_front();
            check("t4_lat1", p.cyc - acc_b1, 1);
            check("t4_tmask1", p.tmask, 4'b0110);
            p = b_q.pop_front();
            check("t4_lat2", p.cyc - acc_b2, 1);
            check("t4_uuid2", p.hdr.uuid, 22);
        end

        // 5: reset mid-gather drops the partial instruction.
        send_a(0, 1, 0, 1, 32'h60, 44'd6, acc);
        send_a(1, 0, 0, 1, 32'h61, 44'd6, acc);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        send4_a(44'd7, 4'b1011, 32'hE0, 32'hE1, 32'hE2, 32'hE3, acc);
        settle();
        check("t5_count", a_q.size(), 1);
        if (a_q.size() > 0) begin
            p = a_q.pop_front();
            check("t5_uuid", p.hdr.uuid, 7);
            check("t5_tmask", p.tmask, 4'b1011);
            check("t5_data", p.data, 128'h000000E3_000000E2_000000E1_000000E0);
        end

        // 6: sop arrives while pid2 is expected; gather restarts.
        send_a(0, 1, 0, 1, 32'hF0, 44'd8, acc);
        send_a(1, 0, 0, 1, 32'hF1, 44'd8, acc);
        send4_a(44'd9, 4'b1110, 32'h90, 32'h91, 32'h92, 32'h93, acc);
        settle();
        check("t6_count", a_q.size(), 1);
        if (a_q.size() > 0) begin
            p = a_q.pop_front();
            check("t6_uuid", p.hdr.uuid, 9);
            check("t6_pc", p.hdr.pc, 30'h409);
            check("t6_tmask", p.tmask, 4'b1110);
            check("t6_data", p.data, 128'h00000093_00000092_00000091_00000090);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
